// File: rtl/eic_pkg.sv
// Shared definitions for the EIC interrupt presentation path: state encoding,
// field widths and the EICR enable bit position.
package eic_pkg;

  localparam int EIC_IRQ_W   = 6;
  localparam int EIC_CNT_W   = 16;
  localparam int EIC_LVL_W   = 8;
  localparam int EIC_OFS_W   = 17;
  localparam int EIC_SHD_W   = 4;
  localparam int EICR_EN_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_CLEAR   = 2'd2,
    ST_GAP     = 2'd3
  } eic_state_e;

  // Level presented to the core: channel index plus one, so zero means "none".
  function automatic logic [EIC_LVL_W-1:0] eic_level(input logic [EIC_IRQ_W-1:0] num);
    return {{(EIC_LVL_W-EIC_IRQ_W){1'b0}}, num} + EIC_LVL_W'(1);
  endfunction

endpackage

// File: rtl/eic_irq_sequencer.sv
// Presents the winning EIC request to the core, holds it until acknowledge,
// then optionally requests the EIFR flag clear for the serviced channel.
//
// state   | meaning
// IDLE    | nothing presented, waiting for an enabled request
// PRESENT | EIC_Interrupt = cur+1, waiting for SI_IAck (may be preempted)
// CLEAR   | clr_req high for cur, waiting for clr_ack
// GAP     | one settle cycle for EIFR and the encoder, then IDLE
module eic_irq_sequencer
  import eic_pkg::*;
#(
  parameter bit                  AUTO_CLEAR = 1'b1,
  parameter logic [EIC_SHD_W-1:0] SHADOW_SET = '0,
  parameter int                  CNT_W      = EIC_CNT_W
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 enable,
  input  logic                 irq_detected,
  input  logic [EIC_IRQ_W-1:0] irq_number,
  input  logic                 SI_IAck,
  output logic [EIC_LVL_W-1:0] EIC_Interrupt,
  output logic [EIC_IRQ_W-1:0] EIC_Vector,
  output logic [EIC_SHD_W-1:0] EIC_ShadowSet,
  output logic [EIC_OFS_W-1:0] EIC_Offset,
  output logic                 clr_req,
  output logic [EIC_IRQ_W-1:0] clr_num,
  input  logic                 clr_ack,
  output logic [CNT_W-1:0]     served_cnt,
  output logic                 ack_err
);

  eic_state_e           state_q, state_d;
  logic [EIC_IRQ_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [EIC_LVL_W-1:0] int_q, int_d;
  logic [EIC_SHD_W-1:0] shd_q, shd_d;
  logic                 req_q, req_d;
  logic [EIC_IRQ_W-1:0] num_q, num_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      int_q   <= '0;
      shd_q   <= '0;
      req_q   <= 1'b0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      int_q   <= int_d;
      shd_q   <= shd_d;
      req_q   <= req_d;
      num_q   <= num_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    err_d   = err_q | (SI_IAck & (state_q != ST_PRESENT));

    unique case (state_q)
      ST_IDLE: begin
        if (enable && irq_detected) begin
          cur_d   = irq_number;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // Ack beats withdraw beats preemption; a dropped request keeps the presented level.
        if (SI_IAck) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = AUTO_CLEAR ? ST_CLEAR : ST_GAP;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end else if (irq_detected && (irq_number > cur_q)) begin
          cur_d = irq_number;
        end
      end
      ST_CLEAR: begin
        if (clr_ack) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from next state so every port comes straight from a flop.
  always_comb begin
    int_d = '0;
    shd_d = '0;
    req_d = 1'b0;
    num_d = '0;
    if (state_d == ST_PRESENT) begin
      int_d = eic_level(cur_d);
      shd_d = SHADOW_SET;
    end
    if (state_d == ST_CLEAR) begin
      req_d = 1'b1;
      num_d = cur_d;
    end
  end

  assign EIC_Interrupt = int_q;
  assign EIC_Vector    = int_q[EIC_IRQ_W-1:0];
  assign EIC_ShadowSet = shd_q;
  assign EIC_Offset    = '0;
  assign clr_req       = req_q;
  assign clr_num       = num_q;
  assign served_cnt    = cnt_q;
  assign ack_err       = err_q;

endmodule

// File: tb/tb_eic_irq_sequencer.sv
// Directed bench: a cycle-accurate vector table for the auto-clear instance,
// plus a hand sequence on a narrow-counter, no-clear instance for counter wrap.
module tb_eic_irq_sequencer;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instance A: AUTO_CLEAR=1, full-width counter
  logic        a_rst, a_en, a_det, a_iack, a_cack;
  logic [5:0]  a_num;
  logic [7:0]  a_int;
  logic [5:0]  a_vec, a_cnum;
  logic [3:0]  a_shd;
  logic [16:0] a_ofs;
  logic        a_req, a_err;
  logic [15:0] a_cnt;

  // Instance B: AUTO_CLEAR=0, 4-bit counter
  logic        b_rst, b_en, b_det, b_iack, b_cack;
  logic [5:0]  b_num;
  logic [7:0]  b_int;
  logic [5:0]  b_vec, b_cnum;
  logic [3:0]  b_shd;
  logic [16:0] b_ofs;
  logic        b_req, b_err;
  logic [3:0]  b_cnt;

  eic_irq_sequencer #(.AUTO_CLEAR(1'b1), .SHADOW_SET(4'h5)) dut_a (
    .CLK(CLK), .RESET(a_rst), .enable(a_en), .irq_detected(a_det),
    .irq_number(a_num), .SI_IAck(a_iack), .EIC_Interrupt(a_int),
    .EIC_Vector(a_vec), .EIC_ShadowSet(a_shd), .EIC_Offset(a_ofs),
    .clr_req(a_req), .clr_num(a_cnum), .clr_ack(a_cack),
    .served_cnt(a_cnt), .ack_err(a_err)
  );

  eic_irq_sequencer #(.AUTO_CLEAR(1'b0), .SHADOW_SET(4'h0), .CNT_W(4)) dut_b (
    .CLK(CLK), .RESET(b_rst), .enable(b_en), .irq_detected(b_det),
    .irq_number(b_num), .SI_IAck(b_iack), .EIC_Interrupt(b_int),
    .EIC_Vector(b_vec), .EIC_ShadowSet(b_shd), .EIC_Offset(b_ofs),
    .clr_req(b_req), .clr_num(b_cnum), .clr_ack(b_cack),
    .served_cnt(b_cnt), .ack_err(b_err)
  );

  typedef struct {
    string      name;
    logic       rst, en, det;
    logic [5:0] num;
    logic       iack, cack;
    logic [7:0] e_int;
    logic       e_req;
    logic [5:0] e_num;
    logic [15:0] e_cnt;
    logic       e_err;
  } vec_t;

  vec_t vq[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input string nm, input logic rst, en, det, input logic [5:0] num,
                     input logic iack, cack, input logic [7:0] e_int, input logic e_req,
                     input logic [5:0] e_num, input logic [15:0] e_cnt, input logic e_err);
    vec_t v;
    v.name = nm; v.rst = rst; v.en = en; v.det = det; v.num = num;
    v.iack = iack; v.cack = cack; v.e_int = e_int; v.e_req = e_req;
    v.e_num = e_num; v.e_cnt = e_cnt; v.e_err = e_err;
    vq.push_back(v);
  endtask

  task automatic step_b(input logic rst, en, det, input logic [5:0] num, input logic iack);
    @(negedge CLK);
    b_rst = rst; b_en = en; b_det = det; b_num = num; b_iack = iack; b_cack = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    a_rst = 1'b1; a_en = 1'b0; a_det = 1'b0; a_num = '0; a_iack = 1'b0; a_cack = 1'b0;
    b_rst = 1'b1; b_en = 1'b0; b_det = 1'b0; b_num = '0; b_iack = 1'b0; b_cack = 1'b0;

    //  name           rst en det num iack cack  int req num cnt err
    add("rst",          1, 0, 0,  5, 0, 0,   0, 0,  0, 0, 0);
    add("idle",         0, 1, 0,  5, 0, 0,   0, 0,  0, 0, 0);
    add("present",      0, 1, 1,  5, 0, 0,   6, 0,  0, 0, 0);
    add("hold_eq",      0, 1, 1,  5, 0, 0,   6, 0,  0, 0, 0);
    add("hold_drop",    0, 1, 0,  5, 0, 0,   6, 0,  0, 0, 0);
    add("ack",          0, 1, 0,  5, 1, 0,   0, 1,  5, 1, 0);
    add("clr_wait_dis", 0, 0, 0,  5, 0, 0,   0, 1,  5, 1, 0);
    add("clr_ack",      0, 0, 0,  5, 0, 1,   0, 0,  0, 1, 0);
    add("gap",          0, 1, 1,  3, 0, 0,   0, 0,  0, 1, 0);
    add("re_present",   0, 1, 1,  3, 0, 0,   4, 0,  0, 1, 0);
    add("preempt",      0, 1, 1, 40, 0, 0,  41, 0,  0, 1, 0);
    add("lower",        0, 1, 1,  2, 0, 0,  41, 0,  0, 1, 0);
    add("ack_vs_pre",   0, 1, 1, 63, 1, 0,   0, 1, 40, 2, 0);
    add("clr_ack2",     0, 1, 0,  0, 0, 1,   0, 0,  0, 2, 0);
    add("gap2",         0, 1, 0,  0, 0, 0,   0, 0,  0, 2, 0);
    add("present7",     0, 1, 1,  7, 0, 0,   8, 0,  0, 2, 0);
    add("withdraw",     0, 0, 1,  7, 0, 0,   0, 0,  0, 2, 0);
    add("dis_idle",     0, 0, 1,  7, 0, 0,   0, 0,  0, 2, 0);
    add("stray_ack",    0, 0, 0,  7, 1, 0,   0, 0,  0, 2, 1);
    add("err_sticky",   0, 1, 0,  7, 0, 0,   0, 0,  0, 2, 1);
    add("present7b",    0, 1, 1,  7, 0, 0,   8, 0,  0, 2, 1);
    add("ack3",         0, 1, 1,  7, 1, 0,   0, 1,  7, 3, 1);
    add("clr_ack_rise", 0, 1, 1,  7, 0, 1,   0, 0,  0, 3, 1);
    add("gap3",         0, 1, 1,  0, 0, 0,   0, 0,  0, 3, 1);
    add("ch0",          0, 1, 1,  0, 0, 0,   1, 0,  0, 3, 1);
    add("ack_ch0",      0, 1, 0,  0, 1, 0,   0, 1,  0, 4, 1);
    add("rst_mid_clr",  1, 1, 0,  0, 0, 0,   0, 0,  0, 0, 0);
    add("post_rst",     0, 0, 0,  0, 0, 0,   0, 0,  0, 0, 0);
    add("ch63",         0, 1, 1, 63, 0, 0,  64, 0,  0, 0, 0);
    add("ack63",        0, 1, 1, 63, 1, 0,   0, 1, 63, 1, 0);
    add("clr_ack63",    0, 1, 1, 63, 0, 1,   0, 0,  0, 1, 0);
    add("gap_stray",    0, 1, 0,  0, 1, 0,   0, 0,  0, 1, 1);
    add("err_hold",     0, 1, 0,  0, 0, 0,   0, 0,  0, 1, 1);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge CLK);
      a_rst = vq[i].rst; a_en = vq[i].en; a_det = vq[i].det; a_num = vq[i].num;
      a_iack = vq[i].iack; a_cack = vq[i].cack;
      @(posedge CLK);
      #1;
      chk({vq[i].name, ".int"}, 32'(a_int), 32'(vq[i].e_int));
      chk({vq[i].name, ".vec"}, 32'(a_vec), 32'(vq[i].e_int[5:0]));
      chk({vq[i].name, ".shadow"}, 32'(a_shd), (vq[i].e_int != 0) ? 32'h5 : 32'h0);
      chk({vq[i].name, ".offset"}, 32'(a_ofs), 32'h0);
      chk({vq[i].name, ".clr_req"}, 32'(a_req), 32'(vq[i].e_req));
      if (vq[i].e_req) chk({vq[i].name, ".clr_num"}, 32'(a_cnum), 32'(vq[i].e_num));
      chk({vq[i].name, ".cnt"}, 32'(a_cnt), 32'(vq[i].e_cnt));
      chk({vq[i].name, ".ack_err"}, 32'(a_err), 32'(vq[i].e_err));
    end

    // AUTO_CLEAR=0 path and counter wrap on the 4-bit instance
    step_b(1'b1, 1'b0, 1'b0, 6'd9, 1'b0);
    chk("b.rst_cnt", 32'(b_cnt), 32'h0);
    step_b(1'b0, 1'b1, 1'b1, 6'd9, 1'b0);
    chk("b.present", 32'(b_int), 32'd10);
    for (int i = 1; i <= 16; i++) begin
      step_b(1'b0, 1'b1, 1'b1, 6'd9, 1'b1);
      chk($sformatf("b.ack%0d.int", i), 32'(b_int), 32'h0);
      chk($sformatf("b.ack%0d.no_clr", i), 32'(b_req), 32'h0);
      chk($sformatf("b.ack%0d.cnt", i), 32'(b_cnt), 32'(i % 16));
      step_b(1'b0, 1'b1, 1'b1, 6'd9, 1'b0);
      chk($sformatf("b.idle%0d.int", i), 32'(b_int), 32'h0);
      step_b(1'b0, 1'b1, 1'b1, 6'd9, 1'b0);
      chk($sformatf("b.pres%0d.int", i), 32'(b_int), 32'd10);
    end
    chk("b.ack_err", 32'(b_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
